fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch unit: credit-limited instruction fetch with an in-order in-flight
// address FIFO, a small decode-side fetch queue and redirect flushing.
// Responses that belong to a path abandoned by a redirect are counted off
// by drop_cnt and never reach the fetch queue.
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Fetch queue storage and bookkeeping
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [CW-1:0] count;

  // In-flight request addresses, oldest first
  logic [31:0]   f_pc [DEPTH];
  logic [AW-1:0] f_rd;
  logic [AW-1:0] f_wr;
  logic [CW-1:0] outstanding;

  // Wrong-path response discard
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_next;
  state_t        state;

  logic [CW:0]   credit_sum;
  logic          has_credit;
  logic          req_fire;
  logic          resp_take;
  logic          resp_drop;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          unused_bits;

  // The low two bits of a redirect target are forced to zero, so they are
  // intentionally not consumed.
  assign unused_bits = ^redirect_pc[1:0];

  // Entries already queued plus those still in memory may never exceed the
  // queue size; a pop in the same cycle does not free a slot until next cycle.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign has_credit = credit_sum < {1'b0, DEPTH_C};

  assign imem_req_valid = !reset && !redirect_valid && has_credit;
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_take = imem_resp_valid && (outstanding != '0) && !reset;
  assign resp_drop = resp_take && (state == FLUSH);
  assign push      = resp_take && !resp_drop && !redirect_valid;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  // Credit makes a push into a full queue unreachable; the guard keeps
  // entries intact should it ever happen anyway.
  assign push_ok = push && ((count != DEPTH_C) || pop);

  assign inst_pc   = inst_valid ? q_pc[q_rd]    : 32'h0;
  assign inst_data = inst_valid ? q_instr[q_rd] : 32'h0;

  // Next PC selection: redirect wins, then sequential advance on an accepted request
  always_comb begin
    next_pc = pc_in;
    if (reset) begin
      next_pc = pc_in;
    end else if (redirect_valid) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      next_pc = pc_in + 32'd4;
    end
  end

  // Drop count follows outstanding on a redirect, otherwise counts discards down
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid) begin
      drop_next = outstanding - CW'(resp_take);
    end else if (resp_drop) begin
      drop_next = drop_cnt - CW'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and counters
  always_ff @(posedge clk) begin
    if (req_fire) begin
      f_pc[f_wr] <= pc_in;
    end
    if (push_ok) begin
      q_pc[q_wr]    <= f_pc[f_rd];
      q_instr[q_wr] <= imem_resp_data;
    end
  end

  // In-flight FIFO pointers and outstanding request count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rd        <= '0;
      f_wr        <= '0;
      outstanding <= '0;
    end else begin
      if (req_fire) begin
        f_wr <= f_wr + AW'(1);
      end
      if (resp_take) begin
        f_rd <= f_rd + AW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
    end
  end

  // Fetch queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_rd  <= '0;
      q_wr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      q_rd  <= '0;
      q_wr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        q_wr <= q_wr + AW'(1);
      end
      if (pop) begin
        q_rd <= q_rd + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // RUN/FLUSH state machine tracking whether wrong-path responses remain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
      if (drop_next != '0) begin
        state <= FLUSH;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand-written reset and
// protocol-error sequences, and a randomized run against a queue-based model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .next_pc(next_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        e_req;
    logic [31:0] e_next;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  // Memory contents: each word is derived from its address
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                              input logic [31:0] pc, input logic rdy,
                              input logic rv, input logic [31:0] rdata,
                              input logic ir, input logic e_req,
                              input logic [31:0] e_next, input logic e_iv,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.pc = pc; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.ir = ir; v.e_req = e_req; v.e_next = e_next;
    v.e_iv = e_iv; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and check outputs just after
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    reset           = 1'b0;
    redirect_valid  = v.redir;
    redirect_pc     = v.rpc;
    pc_in           = v.pc;
    imem_req_ready  = v.rdy;
    imem_resp_valid = v.rv;
    imem_resp_data  = v.rdata;
    inst_ready      = v.ir;
    #1;
    checkOutput({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.e_req});
    checkOutput({tag, ".next_pc"}, next_pc, v.e_next);
    checkOutput({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, v.e_iv});
    if (v.e_req) checkOutput({tag, ".req_addr"}, imem_req_addr, v.pc);
    if (v.e_iv) begin
      checkOutput({tag, ".inst_pc"}, inst_pc, v.e_ipc);
      checkOutput({tag, ".inst_data"}, inst_data, mw(v.e_ipc));
    end
  endtask

  // Hold reset for two cycles and check the reset-state outputs; reset stays high
  task automatic doReset(input logic [31:0] pc);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; pc_in = pc;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst.req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst.next_pc", next_pc, pc);
    checkOutput("rst.inst_pc", inst_pc, 32'h0);
    checkOutput("rst.inst_data", inst_data, 32'h0);
  endtask

  vec_t table_v[$];

  logic [31:0] mq_pc[$];
  logic [31:0] mf[$];
  int          mdrop;
  logic [31:0] pc_reg;

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; pc_in = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b0;

    // Directed table: start, stall/drain, redirect with drop, wrap, held request
    table_v.push_back(mk(0, 0, 32'h0,   1, 0, 0,        1, 1, 32'h4,   0, 0));
    table_v.push_back(mk(0, 0, 32'h4,   1, 1, mw(32'h0), 1, 1, 32'h8,  0, 0));
    table_v.push_back(mk(0, 0, 32'h8,   1, 1, mw(32'h4), 1, 0, 32'h8,  1, 32'h0));
    table_v.push_back(mk(0, 0, 32'h8,   1, 0, 0,        0, 1, 32'hC,   1, 32'h4));
    table_v.push_back(mk(0, 0, 32'hC,   1, 1, mw(32'h8), 0, 0, 32'hC,  1, 32'h4));
    table_v.push_back(mk(0, 0, 32'hC,   1, 0, 0,        0, 0, 32'hC,   1, 32'h4));
    table_v.push_back(mk(0, 0, 32'hC,   1, 0, 0,        1, 0, 32'hC,   1, 32'h4));
    table_v.push_back(mk(0, 0, 32'hC,   1, 0, 0,        0, 1, 32'h10,  1, 32'h8));
    table_v.push_back(mk(1, 32'h103, 32'h10, 1, 0, 0,   0, 0, 32'h100, 1, 32'h8));
    table_v.push_back(mk(0, 0, 32'h100, 1, 0, 0,        0, 1, 32'h104, 0, 0));
    table_v.push_back(mk(0, 0, 32'h104, 1, 1, mw(32'hC), 0, 0, 32'h104, 0, 0));
    table_v.push_back(mk(0, 0, 32'h104, 1, 1, mw(32'h100), 1, 1, 32'h108, 0, 0));
    table_v.push_back(mk(0, 0, 32'h108, 1, 0, 0,        1, 0, 32'h108, 1, 32'h100));
    table_v.push_back(mk(1, 32'hFFFF_FFFE, 32'h108, 1, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0));
    table_v.push_back(mk(0, 0, 32'hFFFF_FFFC, 1, 1, mw(32'h104), 1, 1, 32'h0, 0, 0));
    table_v.push_back(mk(0, 0, 32'h0,   1, 1, mw(32'hFFFF_FFFC), 1, 1, 32'h4, 0, 0));
    table_v.push_back(mk(0, 0, 32'h4,   0, 0, 0,        1, 0, 32'h4,   1, 32'hFFFF_FFFC));
    table_v.push_back(mk(0, 0, 32'h4,   0, 1, mw(32'h0), 1, 1, 32'h4,  0, 0));
    table_v.push_back(mk(0, 0, 32'h4,   1, 0, 0,        1, 1, 32'h8,   1, 32'h0));

    $display("[TB] directed table");
    doReset(32'h0);
    for (int i = 0; i < table_v.size(); i++)
      applyStimulus(table_v[i], $sformatf("tbl%0d", i));

    $display("[TB] response with nothing outstanding");
    doReset(32'h0);
    applyStimulus(mk(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0, 0, 0), "spur0");
    applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h0, 0, 0), "spur1");
    applyStimulus(mk(0, 0, 32'h0, 1, 0, 0, 1, 1, 32'h4, 0, 0), "spur2");

    $display("[TB] reset mid-operation");
    doReset(32'h0);
    applyStimulus(mk(0, 0, 32'h0, 1, 0, 0, 0, 1, 32'h4, 0, 0), "mid0");
    applyStimulus(mk(0, 0, 32'h4, 1, 1, mw(32'h0), 0, 1, 32'h8, 0, 0), "mid1");
    applyStimulus(mk(0, 0, 32'h8, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0), "mid2");
    #2;
    reset = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = mw(32'h4);
    #1;
    checkOutput("mid.rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("mid.rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("mid.rst_next_pc", next_pc, 32'h8);
    applyStimulus(mk(0, 0, 32'h200, 1, 0, 0, 1, 1, 32'h204, 0, 0), "mid3");
    applyStimulus(mk(0, 0, 32'h204, 1, 0, 0, 1, 1, 32'h208, 0, 0), "mid4");
    applyStimulus(mk(0, 0, 32'h208, 1, 1, mw(32'h200), 1, 0, 32'h208, 0, 0), "mid5");
    applyStimulus(mk(0, 0, 32'h208, 1, 0, 0, 1, 0, 32'h208, 1, 32'h200), "mid6");

    $display("[TB] randomized run against reference model");
    doReset(32'h0);
    pc_reg = 32'h0;
    mq_pc.delete();
    mf.delete();
    mdrop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_redir, r_rdy, r_rv, r_ir, e_req, e_iv, acc;
      logic [31:0] r_rpc, r_data, e_next, popped;
      r_redir = ($urandom % 16) == 0;
      r_rpc   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      r_rdy   = ($urandom % 4) != 0;
      r_ir    = ($urandom % 3) != 0;
      if (mf.size() > 0) begin
        r_rv   = ($urandom % 3) != 0;
        r_data = mw(mf[0]);
      end else begin
        r_rv   = ($urandom % 16) == 0;
        r_data = $urandom;
      end
      @(negedge clk);
      reset = 1'b0; redirect_valid = r_redir; redirect_pc = r_rpc;
      pc_in = pc_reg; imem_req_ready = r_rdy; imem_resp_valid = r_rv;
      imem_resp_data = r_data; inst_ready = r_ir;
      #1;
      e_req = !r_redir && ((mq_pc.size() + mf.size()) < DEPTH);
      acc = e_req && r_rdy;
      if (r_redir) e_next = {r_rpc[31:2], 2'b00};
      else if (acc) e_next = pc_reg + 32'd4;
      else e_next = pc_reg;
      e_iv = mq_pc.size() != 0;
      checkOutput("rnd.req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      checkOutput("rnd.next_pc", next_pc, e_next);
      checkOutput("rnd.inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
      if (e_req) checkOutput("rnd.req_addr", imem_req_addr, pc_reg);
      if (e_iv) begin
        checkOutput("rnd.inst_pc", inst_pc, mq_pc[0]);
        checkOutput("rnd.inst_data", inst_data, mw(mq_pc[0]));
      end
      // Reference update at the coming rising edge
      if (r_redir) begin
        if (r_rv && mf.size() > 0) popped = mf.pop_front();
        mq_pc.delete();
        mdrop = mf.size();
      end else begin
        if (e_iv && r_ir) popped = mq_pc.pop_front();
        if (r_rv && mf.size() > 0) begin
          popped = mf.pop_front();
          if (mdrop > 0) mdrop--;
          else mq_pc.push_back(popped);
        end
      end
      if (acc) mf.push_back(pc_reg);
      pc_reg = e_next;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
